// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the sequencer state enum, the instruction width, the ecall encoding
// and the {pc, instr} entry carried through the prefetch FIFO to decode.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] ECALL   = 32'h0000_0073;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with synchronous flush (flush beats push/pop).
// Latency: a push is visible at head the next cycle; head is combinational from storage.
// Backpressure: push is accepted when not full, or when full with a same-cycle pop.
// Ports: clk/rst_n; flush, push+wdata, pop in; full, empty, count, head out.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // Full-and-popping still has room: the head slot frees as the new word lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// RV32I fetch controller: walks pc_q through a combinational imem, buffers
//   {pc, instr} in a prefetch FIFO for decode, takes redirects, halts on ecall/fault.
// Latency: word fetched in cycle N is at out_* in cycle N+1; 1 instr/cycle sustained.
// Backpressure: out_ready low fills the FIFO, then pc_q holds until a slot frees.
// Ports: clk, rst_n, en | imem_addr/imem_rdata | out_valid/ready/instr/pc |
//   redirect_valid/pc | halted, fault (sticky), fetch_count (16-bit, wrapping).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [29:0]   LIMIT   = 30'(IMEM_WORDS);

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [15:0]  fcnt_q, fcnt_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_wdata;
  logic         space;

  // A redirect kills the head in the same cycle so decode never sees a
  // wrong-path instruction once execute has resolved the branch.
  assign out_valid  = !fifo_empty && !redirect_valid;
  assign fifo_pop   = out_valid && out_ready;
  assign space      = (fifo_count < DEPTH_C) || (fifo_full && fifo_pop);
  assign fifo_wdata = '{pc: pc_q, instr: imem_rdata};

  assign imem_addr   = pc_q;
  assign out_instr   = fifo_head.instr;
  assign out_pc      = fifo_head.pc;
  assign halted      = (state_q == HALT);
  assign fault       = fault_q;
  assign fetch_count = fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fcnt_d     = fcnt_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc & ~32'd3;
        end else if (!en) begin
          pc_d = pc_q;
        end else if (pc_q[31:2] >= LIMIT) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (space) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + 32'd4;
          fcnt_d    = fcnt_q + 16'd1;
          // The ecall itself still goes to decode; nothing after it is fetched.
          if (imem_rdata == ECALL) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc & ~32'd3;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the expected decode stream is the
// architectural fetch sequence from each start pc (reset or redirect),
// ending at ecall or at the first out-of-range word.
module tb_fetch_sequencer;

  localparam logic [31:0] ECALL_W = 32'h0000_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr[31:2] < 30'd16) ? mem[imem_addr[5:2]] : 32'h0;

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .IMEM_WORDS(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  int          total = 0;
  int          bad   = 0;
  exp_t        expq[$];
  logic        exp_fault;
  logic [31:0] exp_end_pc;
  int          exp_len;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected decode stream from a start address: sequential words until an
  // ecall (included) or a word index past the end of memory.
  task automatic start_epoch(input logic [31:0] target);
    logic [31:0] pc;
    logic [31:0] w;
    expq.delete();
    pc        = target & ~32'd3;
    exp_fault = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (pc[31:2] >= 30'd16) begin
        exp_fault = 1'b1;
        break;
      end
      w = mem[pc[5:2]];
      expq.push_back('{pc: pc, instr: w});
      pc = pc + 32'd4;
      if (w == ECALL_W) break;
    end
    exp_end_pc = pc;
    exp_len    = expq.size();
  endtask

  // Monitor: redirect masking, head stability under backpressure, transfers.
  logic        hold;
  logic [31:0] hold_pc, hold_instr;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (redirect_valid) begin
        check32("redirect_mask", {31'b0, out_valid}, 32'd0);
      end else if (hold) begin
        check32("hold_valid", {31'b0, out_valid}, 32'd1);
        check32("hold_pc", out_pc, hold_pc);
        check32("hold_instr", out_instr, hold_instr);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got pc %h want no transfer", out_pc);
        end else begin
          e = expq.pop_front();
          check32("xfer_pc", out_pc, e.pc);
          check32("xfer_instr", out_instr, e.instr);
        end
      end
      hold       = out_valid && !out_ready;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    expq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    start_epoch(32'h0);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    start_epoch(target);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int n;
    out_ready = 1'b1;
    en        = 1'b1;
    n         = 0;
    do begin
      tick();
      n++;
    end while (!(halted && !out_valid) && n < 300);
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got running after %0d cycles want halted and drained", tag, n);
    end
    check32({tag, "_leftover"}, expq.size(), 32'd0);
    check32({tag, "_halted"}, {31'b0, halted}, 32'd1);
    check32({tag, "_end_pc"}, imem_addr, exp_end_pc);
    if (exp_fault) check32({tag, "_fault"}, {31'b0, fault}, 32'd1);
  endtask

  task automatic fill_mem_random(input int ecall_idx);
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom();
      if (mem[i] == ECALL_W) mem[i] = 32'h0000_0013;
    end
    if (ecall_idx >= 0 && ecall_idx < 16) mem[ecall_idx] = ECALL_W;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    en             = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fill_mem_random(5);
    mem[0] = 32'hFFC4_A303;
    mem[1] = 32'h0032_A023;
    mem[2] = 32'h4062_84B3;
    mem[3] = 32'h0062_E4B3;

    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check32("rst_valid", {31'b0, out_valid}, 32'd0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_out_instr", out_instr, 32'h0);
    check32("rst_halted", {31'b0, halted}, 32'd0);
    check32("rst_fault", {31'b0, fault}, 32'd0);
    check32("rst_count", {16'b0, fetch_count}, 32'd0);
    do_reset();

    // Basic stream: first valid two cycles after en rises.
    tick();
    check32("idle_addr", imem_addr, 32'h0);
    en = 1'b1;
    tick();
    check32("lat_valid_n1", {31'b0, out_valid}, 32'd0);
    tick();
    check32("lat_valid_n2", {31'b0, out_valid}, 32'd1);
    check32("lat_pc", out_pc, 32'h0);
    run_to_halt("ecall");
    check32("ecall_count", {16'b0, fetch_count}, 32'd6);
    check32("ecall_exp_len", exp_len, 32'd6);

    // Backpressure: FIFO fills at DEPTH, pc holds, head stable.
    out_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    check32("bp_addr", imem_addr, 32'h8);
    check32("bp_head_pc", out_pc, 32'h0);
    check32("bp_valid", {31'b0, out_valid}, 32'd1);
    check32("bp_count", {16'b0, fetch_count}, 32'd2);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    check32("bp2_head_pc", out_pc, 32'h8);

    // Redirect with full FIFO and ready high.
    out_ready = 1'b1;
    pulse_redirect(32'h0000_001E);
    check32("redir_addr", imem_addr, 32'h1C);
    run_to_halt("redir");

    // Fault at word 16, then recovery with sticky fault.
    pulse_redirect(32'h0000_0040);
    run_to_halt("fault");
    pulse_redirect(32'h0);
    check32("recover_halted", {31'b0, halted}, 32'd0);
    check32("recover_fault", {31'b0, fault}, 32'd1);
    run_to_halt("recover");
    check32("sticky_fault", {31'b0, fault}, 32'd1);

    // Randomized traffic: ready/en gaps and redirects anywhere in or past memory.
    for (int round = 0; round < 4; round++) begin
      fill_mem_random(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(4, 15)));
      en        = 1'b1;
      out_ready = 1'b1;
      do_reset();
      tick();
      tick();
      for (int c = 0; c < 300; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        en        = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) == 0) pulse_redirect($urandom_range(0, 32'h47));
        else tick();
      end
      run_to_halt("rand");
    end

    // Async reset mid-stream.
    fill_mem_random(int'($urandom_range(6, 15)));
    pulse_redirect(32'h0);
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    expq.delete();
    #1;
    check32("arst_valid", {31'b0, out_valid}, 32'd0);
    check32("arst_addr", imem_addr, 32'h0);
    check32("arst_out_pc", out_pc, 32'h0);
    check32("arst_count", {16'b0, fetch_count}, 32'd0);
    check32("arst_halted", {31'b0, halted}, 32'd0);
    check32("arst_fault", {31'b0, fault}, 32'd0);
    #4 rst_n = 1'b1;
    start_epoch(32'h0);
    run_to_halt("arst");
    check32("arst_fetch_count", {16'b0, fetch_count}, exp_len);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
